alu_slice_sequencer: RTL and testbench

Executes a WIDTH-bit bitwise logic operation (AND/OR/XOR/NOT) by driving one shared SLICE-bit logic slice for WIDTH/SLICE consecutive cycles, least-significant slice first. The block accumulates the result and the N/Z/V/C flags across slices. It sits between the instruction decode/issue stage and the register writeback stage, with a valid/ready handshake on each side. It trades latency for a narrow logic datapath.

---
 rtl/alu_seq_pkg.sv | 13 +
 rtl/alu_logic_slice.sv | 17 +
 rtl/alu_slice_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_slice_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op encodings, FSM states and flag layout shared by the slice sequencer
package alu_seq_pkg;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  localparam logic [3:0] FLAGS_RST = 4'b0100;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_logic_slice.sv
// alu_logic_slice: stateless SLICE-bit AND/OR/XOR/NOT unit shared across all slices
module alu_logic_slice
  import alu_seq_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [1:0]       op,
  output logic [SLICE-1:0] y
);
  always_comb begin
    y = op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_XOR ? a ^ b : ~a;
  end
endmodule

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: WIDTH-bit logic op done SLICE bits per cycle, LSB slice first; ALU_SEQ_PERF_CNT_EN adds ops_done/busy
module alu_slice_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic [3:0]       rsp_flags_n_z_v_c
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]      ops_done,
  output logic             busy
`endif
);
  localparam int N  = WIDTH / SLICE;
  localparam int IW = $clog2(N);
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, out_q, out_d;
  logic             z_q, z_d, req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [3:0]       flags_q, flags_d;
  logic [SLICE-1:0] sl_a, sl_b, sl_y;
  logic             last;
  assign sl_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign sl_b = b_q[int'(idx_q)*SLICE +: SLICE];
  assign last = idx_q == IW'(N - 1);
  alu_logic_slice #(.SLICE(SLICE)) u_slice (.a(sl_a), .b(sl_b), .op(op_q), .y(sl_y));
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    z_d         = z_q;
    out_d       = out_q;
    flags_d     = flags_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    if (state_q == IDLE && req_valid) begin
      state_d     = RUN;
      op_d        = req_op;
      a_d         = req_a;
      b_d         = req_b;
      acc_d       = '0;
      z_d         = 1'b1;
      idx_d       = '0;
      req_ready_d = 1'b0;
    end else if (state_q == RUN) begin
      acc_d[int'(idx_q)*SLICE +: SLICE] = sl_y;
      z_d   = z_q & ~|sl_y;
      idx_d = last ? idx_q : idx_q + 1'b1;
      if (last) begin
        // Result and flags are registered here so they never show a partial value
        state_d         = DONE;
        rsp_valid_d     = 1'b1;
        out_d           = acc_d;
        flags_d         = '0;
        flags_d[FLAG_N] = acc_d[WIDTH-1];
        flags_d[FLAG_Z] = z_d;
        flags_d[FLAG_V] = 1'b0;
        flags_d[FLAG_C] = 1'b0;
      end
    end else if (state_q == DONE && rsp_ready) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
      req_ready_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      z_q         <= 1'b1;
      out_q       <= '0;
      flags_q     <= FLAGS_RST;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign req_ready         = req_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_out           = out_q;
  assign rsp_flags_n_z_v_c = flags_q;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] ops_q, ops_d;
  always_comb begin
    ops_d = (rsp_valid_q && rsp_ready) ? ops_q + 16'd1 : ops_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ops_q <= '0;
    else        ops_q <= ops_d;
  end
  assign ops_done = ops_q;
  assign busy     = state_q != IDLE;
`endif
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb_alu_slice_sequencer: directed checks of latency, results, flags, backpressure and async reset
module tb_alu_slice_sequencer;
  logic        clk, rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a, req_b, rsp_out;
  logic [3:0]  rsp_flags_n_z_v_c;
  int tests, failed;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] ops_done;
  logic        busy;
  logic [15:0] exp_ops;
`endif
  alu_slice_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_flags_n_z_v_c(rsp_flags_n_z_v_c)
`ifdef ALU_SEQ_PERF_CNT_EN
    , .ops_done(ops_done), .busy(busy)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    chk("accept_ready", req_ready, 1);
`ifdef ALU_SEQ_PERF_CNT_EN
    chk("busy_idle", busy, 0);
`endif
    tick();
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_a = 16'($urandom);
    req_b = 16'($urandom);
    chk("run_not_ready", req_ready, 0);
`ifdef ALU_SEQ_PERF_CNT_EN
    chk("busy_run", busy, 1);
`endif
  endtask
  task automatic finish(input string tag, input logic [15:0] exp_out, input logic [3:0] exp_flags, input bit hs);
    repeat (3) tick();
    chk({tag, "_valid_early"}, rsp_valid, 0);
    tick();
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_out"}, rsp_out, exp_out);
    chk({tag, "_flags"}, rsp_flags_n_z_v_c, 16'(exp_flags));
    if (hs) begin
`ifdef ALU_SEQ_PERF_CNT_EN
      chk("busy_done", busy, 1);
      exp_ops++;
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_valid_drop"}, rsp_valid, 0);
      chk({tag, "_ready_back"}, req_ready, 1);
`ifdef ALU_SEQ_PERF_CNT_EN
      chk("ops_done", ops_done, exp_ops);
`endif
    end
  endtask
  initial begin
    tests = 0;
    failed = 0;
`ifdef ALU_SEQ_PERF_CNT_EN
    exp_ops = '0;
`endif
    rst_n = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    req_op = 2'($urandom);
    req_a = 16'($urandom);
    req_b = 16'($urandom);
    #22;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_out", rsp_out, 16'h0000);
    chk("rst_flags", rsp_flags_n_z_v_c, 16'h0004);
`ifdef ALU_SEQ_PERF_CNT_EN
    chk("rst_ops", ops_done, 0);
    chk("rst_busy", busy, 0);
`endif
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    start(2'b01, 16'h8001, 16'h0F00);
    finish("or", 16'h8F01, 4'b1000, 1);
    start(2'b10, 16'hA5A5, 16'hA5A5);
    finish("xor0", 16'h0000, 4'b0100, 1);
    start(2'b00, 16'h000F, 16'hF000);
    finish("and0", 16'h0000, 4'b0100, 1);
    start(2'b11, 16'h00FF, 16'h1234);
    finish("not", 16'hFF00, 4'b1000, 0);
    req_valid = 1'b1;
    req_op = 2'b10;
    req_a = 16'h1234;
    req_b = 16'h00FF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_out", rsp_out, 16'hFF00);
      chk("bp_flags", rsp_flags_n_z_v_c, 16'h0008);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`ifdef ALU_SEQ_PERF_CNT_EN
    exp_ops++;
    chk("bp_ops", ops_done, exp_ops);
`endif
    chk("bp_ready_after", req_ready, 1);
    chk("bp_valid_after", rsp_valid, 0);
    chk("bp_out_kept", rsp_out, 16'hFF00);
    tick();
    req_valid = 1'b0;
    chk("bp_accepted", req_ready, 0);
    finish("xor2", 16'h12CB, 4'b0000, 1);
    start(2'b01, 16'hFFFF, 16'hFFFF);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_out", rsp_out, 16'h0000);
    chk("mid_rst_flags", rsp_flags_n_z_v_c, 16'h0004);
`ifdef ALU_SEQ_PERF_CNT_EN
    exp_ops = '0;
    chk("mid_rst_ops", ops_done, 0);
    chk("mid_rst_busy", busy, 0);
`endif
    #2;
    rst_n = 1'b1;
    tick();
    repeat (6) begin
      tick();
      chk("post_rst_idle_valid", rsp_valid, 0);
    end
    start(2'b00, 16'h0F0F, 16'h00FF);
    finish("and_post", 16'h000F, 4'b0000, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
